// File: rtl/a314_spi_pkg.sv
// Shared definitions for the SPI-to-SRAM bridge:
// FSM states, command decode position and the idle shift byte.
package a314_spi_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR2,
        ADDR1,
        ADDR0,
        RD_ISSUE,
        RD_WAIT,
        RD_SETTLE,
        RD_READY,
        WR_DATA,
        WR_WAIT,
        DRAIN
    } state_t;

    localparam int CMD_RD_BIT = 7;
    localparam logic [7:0] IDLE_TX = 8'hFF;

endpackage

// File: rtl/spi_sram_toggle_req.sv
// Toggle request channel to the SRAM arbiter: holds the request
// fields stable while spi_req differs from spi_ack.
module spi_sram_toggle_req (
    input  logic        clk200,
    input  logic        reset,
    input  logic        issue,
    input  logic        rd,
    input  logic [20:0] byte_addr,
    input  logic [7:0]  wdata,
    input  logic        ack,
    output logic        req,
    output logic        read,
    output logic [19:0] address,
    output logic        ub,
    output logic [7:0]  data,
    output logic        pending
);

    assign pending = req != ack;

    // Issue is ignored while a request is outstanding.
    always_ff @(posedge clk200 or posedge reset) begin
        if (reset) begin
            req     <= 1'b0;
            read    <= 1'b1;
            address <= '0;
            ub      <= 1'b0;
            data    <= '0;
        end else if (issue && !pending) begin
            req     <= ~req;
            read    <= rd;
            address <= byte_addr[20:1];
            ub      <= ~byte_addr[0];
            data    <= wdata;
        end
    end

endmodule

// File: rtl/spi_sram_bridge.sv
// SPI slave frame decoder bridging byte streams to 16-bit SRAM
// word requests, with read prefetch and sticky under/overrun flags.
module spi_sram_bridge
    import a314_spi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 5
) (
    input  logic        clk200,
    input  logic        reset,
    input  logic        cs_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  tx_byte,
    output logic        spi_req,
    input  logic        spi_ack,
    output logic        spi_read,
    output logic [19:0] spi_address,
    output logic        spi_ub,
    output logic [7:0]  spi_out_sram_in,
    input  logic [15:0] spi_in_sram_out,
    output logic        overrun,
    output logic        underrun
);

    localparam int CW = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    state_t state, state_n;
    logic [20:0]   addr;
    logic [CW-1:0] cnt;
    logic rd_cmd, pending;
    logic start, ld_cmd, ld_a2, ld_a1, ld_a0;
    logic issue, issue_rd, latch;
    logic cnt_start, cnt_inc, set_ovr, set_udr;

    spi_sram_toggle_req u_req (
        .clk200    (clk200),
        .reset     (reset),
        .issue     (issue),
        .rd        (issue_rd),
        .byte_addr (addr),
        .wdata     (rx_byte),
        .ack       (spi_ack),
        .req       (spi_req),
        .read      (spi_read),
        .address   (spi_address),
        .ub        (spi_ub),
        .data      (spi_out_sram_in),
        .pending   (pending)
    );

    always_ff @(posedge clk200 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        ld_cmd    = 1'b0;
        ld_a2     = 1'b0;
        ld_a1     = 1'b0;
        ld_a0     = 1'b0;
        issue     = 1'b0;
        issue_rd  = 1'b0;
        latch     = 1'b0;
        cnt_start = 1'b0;
        cnt_inc   = 1'b0;
        set_ovr   = 1'b0;
        set_udr   = 1'b0;
        // Frame end wins over everything, including a running settle.
        if (state != IDLE && state != DRAIN && !cs_active) begin
            state_n = pending ? DRAIN : IDLE;
        end else begin
            unique case (state)
                IDLE: if (cs_active) begin
                    start   = 1'b1;
                    state_n = CMD;
                end
                CMD: if (rx_valid) begin
                    ld_cmd  = 1'b1;
                    state_n = ADDR2;
                end
                ADDR2: if (rx_valid) begin
                    ld_a2   = 1'b1;
                    state_n = ADDR1;
                end
                ADDR1: if (rx_valid) begin
                    ld_a1   = 1'b1;
                    state_n = ADDR0;
                end
                ADDR0: if (rx_valid) begin
                    ld_a0   = 1'b1;
                    state_n = rd_cmd ? RD_ISSUE : WR_DATA;
                end
                RD_ISSUE: begin
                    issue    = 1'b1;
                    issue_rd = 1'b1;
                    set_udr  = rx_valid;
                    state_n  = RD_WAIT;
                end
                RD_WAIT: begin
                    set_udr = rx_valid;
                    if (!pending) begin
                        if (SETTLE_CYCLES <= 1) begin
                            latch   = 1'b1;
                            state_n = RD_READY;
                        end else begin
                            cnt_start = 1'b1;
                            state_n   = RD_SETTLE;
                        end
                    end
                end
                RD_SETTLE: begin
                    set_udr = rx_valid;
                    if (cnt == LAST) begin
                        latch   = 1'b1;
                        state_n = RD_READY;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                RD_READY: if (rx_valid) state_n = RD_ISSUE;
                WR_DATA: if (rx_valid) begin
                    issue   = 1'b1;
                    state_n = WR_WAIT;
                end
                WR_WAIT: begin
                    set_ovr = rx_valid;
                    if (!pending) state_n = WR_DATA;
                end
                DRAIN: if (!pending) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk200 or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            cnt      <= '0;
            rd_cmd   <= 1'b0;
            tx_byte  <= IDLE_TX;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (start) begin
                tx_byte  <= IDLE_TX;
                overrun  <= 1'b0;
                underrun <= 1'b0;
            end
            if (ld_cmd) rd_cmd       <= rx_byte[CMD_RD_BIT];
            if (ld_a2)  addr[20:16]  <= rx_byte[4:0];
            if (ld_a1)  addr[15:8]   <= rx_byte;
            if (ld_a0)  addr[7:0]    <= rx_byte;
            // 21-bit counter wraps 1FFFFF -> 0 on its own.
            if (latch || (issue && !issue_rd))
                addr <= addr + 21'd1;
            if (cnt_start)    cnt <= CW'(1);
            else if (cnt_inc) cnt <= cnt + CW'(1);
            if (set_udr) begin
                underrun <= 1'b1;
                tx_byte  <= IDLE_TX;
            end
            if (latch)
                tx_byte <= spi_ub ? spi_in_sram_out[15:8]
                                  : spi_in_sram_out[7:0];
            if (set_ovr) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Directed bench for spi_sram_bridge with a toggle-ack arbiter
// model and a request monitor.
module tb_spi_sram_bridge;
    import a314_spi_pkg::*;

    localparam int SETTLE = 5;

    logic        clk200 = 1'b0;
    logic        reset = 1'b1;
    logic        cs_active = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  tx_byte;
    logic        spi_req;
    logic        spi_ack;
    logic        spi_read;
    logic [19:0] spi_address;
    logic        spi_ub;
    logic [7:0]  spi_out_sram_in;
    logic [15:0] spi_in_sram_out = 16'h0000;
    logic        overrun;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    bit arb_en = 1'b1;
    int ack_delay = 2;
    int man_cnt = 0;
    int man_done = 0;
    int wait_cnt = 0;

    logic [19:0] q_addr[$];
    logic        q_ub[$];
    logic [7:0]  q_data[$];
    logic        q_rd[$];
    int          multi_out = 0;
    logic        last_req = 1'b0;
    logic        last_ack = 1'b0;

    spi_sram_bridge #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk200          (clk200),
        .reset           (reset),
        .cs_active       (cs_active),
        .rx_valid        (rx_valid),
        .rx_byte         (rx_byte),
        .tx_byte         (tx_byte),
        .spi_req         (spi_req),
        .spi_ack         (spi_ack),
        .spi_read        (spi_read),
        .spi_address     (spi_address),
        .spi_ub          (spi_ub),
        .spi_out_sram_in (spi_out_sram_in),
        .spi_in_sram_out (spi_in_sram_out),
        .overrun         (overrun),
        .underrun        (underrun)
    );

    initial forever #5 clk200 = ~clk200;

    // Arbiter: automatic delayed ack, or manual ack on request.
    initial begin
        spi_ack = 1'b0;
        forever begin
            @(negedge clk200);
            #1;
            if (reset) begin
                spi_ack  = 1'b0;
                wait_cnt = 0;
            end else if (arb_en) begin
                if (spi_req !== spi_ack) begin
                    if (wait_cnt >= ack_delay - 1) begin
                        spi_ack  = spi_req;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else if (man_cnt != man_done) begin
                spi_ack  = spi_req;
                man_done = man_cnt;
            end
        end
    end

    // Request monitor: logs every spi_req toggle.
    initial forever begin
        @(negedge clk200);
        #2;
        if (!reset && spi_req !== last_req) begin
            if (last_req !== last_ack) multi_out++;
            q_addr.push_back(spi_address);
            q_ub.push_back(spi_ub);
            q_data.push_back(spi_out_sram_in);
            q_rd.push_back(spi_read);
        end
        last_req = spi_req;
        last_ack = spi_ack;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk200);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk200);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk200);
    endtask

    task automatic send_hdr(input logic [7:0] c, input logic [7:0] a2,
                            input logic [7:0] a1, input logic [7:0] a0);
        send_byte(c, 2);
        send_byte(a2, 2);
        send_byte(a1, 2);
        send_byte(a0, 2);
    endtask

    task automatic start_frame();
        @(negedge clk200);
        cs_active = 1'b1;
        repeat (2) @(negedge clk200);
    endtask

    task automatic end_frame();
        @(negedge clk200);
        cs_active = 1'b0;
        repeat (3) @(negedge clk200);
    endtask

    task automatic wait_pending(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (spi_req !== spi_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk200);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk200);
        checks++;
        if (tx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL rst_tx: got %h want ff", tx_byte);
        end
        checks++;
        if (spi_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req: got %b want 0", spi_req);
        end
        checks++;
        if (spi_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_read: got %b want 1", spi_read);
        end
        checks++;
        if (spi_address !== 20'h0) begin
            errors++;
            $display("FAIL rst_addr: got %h want 0", spi_address);
        end
        checks++;
        if (spi_ub !== 1'b0) begin
            errors++;
            $display("FAIL rst_ub: got %b want 0", spi_ub);
        end
        checks++;
        if (spi_out_sram_in !== 8'h00) begin
            errors++;
            $display("FAIL rst_data: got %h want 0", spi_out_sram_in);
        end
        checks++;
        if (overrun !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: got %b%b want 00", overrun, underrun);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk200);
    endtask

    task automatic test_write();
        int base;
        logic r0;
        base = q_addr.size();
        r0 = spi_req;
        ack_delay = 2;
        start_frame();
        send_hdr(8'h00, 8'h00, 8'h10, 8'h00);
        send_byte(8'hAA, 4);
        send_byte(8'hBB, 4);
        repeat (4) @(negedge clk200);
        end_frame();
        checks++;
        if (q_addr.size() - base !== 2) begin
            errors++;
            $display("FAIL wr_count: got %0d want 2", q_addr.size() - base);
        end
        checks++;
        if (q_rd[base] !== 1'b0 || q_addr[base] !== 20'h00800
            || q_ub[base] !== 1'b1 || q_data[base] !== 8'hAA) begin
            errors++;
            $display("FAIL wr_req0: got rd=%b a=%h ub=%b d=%h want 0 00800 1 aa",
                     q_rd[base], q_addr[base], q_ub[base], q_data[base]);
        end
        checks++;
        if (q_rd[base+1] !== 1'b0 || q_addr[base+1] !== 20'h00800
            || q_ub[base+1] !== 1'b0 || q_data[base+1] !== 8'hBB) begin
            errors++;
            $display("FAIL wr_req1: got rd=%b a=%h ub=%b d=%h want 0 00800 0 bb",
                     q_rd[base+1], q_addr[base+1], q_ub[base+1], q_data[base+1]);
        end
        checks++;
        if (spi_req !== r0) begin
            errors++;
            $display("FAIL wr_parity: got %b want %b", spi_req, r0);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL wr_ovr: got %b want 0", overrun);
        end
    endtask

    task automatic test_read_settle();
        int base;
        bit ok;
        base = q_addr.size();
        arb_en = 1'b0;
        spi_in_sram_out = 16'h1234;
        start_frame();
        send_byte(8'h80, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h01, 0);
        wait_pending(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rd_issue: got no request want one");
        end
        checks++;
        if (spi_read !== 1'b1 || spi_address !== 20'h0 || spi_ub !== 1'b0) begin
            errors++;
            $display("FAIL rd_fields: got rd=%b a=%h ub=%b want 1 00000 0",
                     spi_read, spi_address, spi_ub);
        end
        man_cnt++;
        repeat (SETTLE - 1) @(negedge clk200);
        checks++;
        if (tx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL rd_early: got %h want ff", tx_byte);
        end
        @(negedge clk200);
        checks++;
        if (tx_byte !== 8'h34) begin
            errors++;
            $display("FAIL rd_latch: got %h want 34", tx_byte);
        end
        repeat (4) @(negedge clk200);
        end_frame();
        arb_en = 1'b1;
        checks++;
        if (q_addr.size() - base !== 1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL rd_once: got n=%0d udr=%b want 1 0",
                     q_addr.size() - base, underrun);
        end
    endtask

    task automatic test_overrun();
        int base;
        base = q_addr.size();
        ack_delay = 20;
        start_frame();
        send_hdr(8'h00, 8'h00, 8'h00, 8'h02);
        send_byte(8'h11, 2);
        send_byte(8'h22, 0);
        repeat (30) @(negedge clk200);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %b want 1", overrun);
        end
        end_frame();
        ack_delay = 2;
        checks++;
        if (q_addr.size() - base !== 1) begin
            errors++;
            $display("FAIL ovr_count: got %0d want 1", q_addr.size() - base);
        end
        checks++;
        if (q_addr[base] !== 20'h1 || q_ub[base] !== 1'b1
            || q_data[base] !== 8'h11) begin
            errors++;
            $display("FAIL ovr_req: got a=%h ub=%b d=%h want 00001 1 11",
                     q_addr[base], q_ub[base], q_data[base]);
        end
        checks++;
        if (multi_out !== 0) begin
            errors++;
            $display("FAIL one_outstanding: got %0d want 0", multi_out);
        end
    endtask

    task automatic test_underrun();
        int base;
        base = q_addr.size();
        start_frame();
        send_hdr(8'h80, 8'h00, 8'h00, 8'h00);
        send_byte(8'h00, 15);
        end_frame();
        checks++;
        if (underrun !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL udr_flags: got udr=%b ovr=%b want 1 0",
                     underrun, overrun);
        end
        checks++;
        if (q_addr.size() - base !== 1) begin
            errors++;
            $display("FAIL udr_count: got %0d want 1", q_addr.size() - base);
        end
    endtask

    task automatic test_wrap();
        int base;
        base = q_addr.size();
        spi_in_sram_out = 16'hA55A;
        start_frame();
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b want 0", underrun);
        end
        send_byte(8'h80, 2);
        send_byte(8'h1F, 2);
        send_byte(8'hFF, 2);
        send_byte(8'hFF, 15);
        checks++;
        if (tx_byte !== 8'h5A) begin
            errors++;
            $display("FAIL wrap_tx0: got %h want 5a", tx_byte);
        end
        send_byte(8'h00, 15);
        checks++;
        if (tx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL wrap_tx1: got %h want a5", tx_byte);
        end
        send_byte(8'h00, 15);
        end_frame();
        checks++;
        if (q_addr[base] !== 20'hFFFFF || q_ub[base] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_req0: got a=%h ub=%b want fffff 0",
                     q_addr[base], q_ub[base]);
        end
        checks++;
        if (q_addr[base+1] !== 20'h0 || q_ub[base+1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_req1: got a=%h ub=%b want 00000 1",
                     q_addr[base+1], q_ub[base+1]);
        end
        checks++;
        if (q_addr.size() - base !== 3 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL wrap_count: got n=%0d udr=%b want 3 0",
                     q_addr.size() - base, underrun);
        end
    endtask

    task automatic test_drain();
        int base;
        bit ok;
        base = q_addr.size();
        arb_en = 1'b0;
        start_frame();
        send_hdr(8'h00, 8'h00, 8'h00, 8'h00);
        send_byte(8'h5C, 0);
        wait_pending(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_issue: got no request want one");
        end
        cs_active = 1'b0;
        repeat (10) @(negedge clk200);
        checks++;
        if (dut.state !== DRAIN) begin
            errors++;
            $display("FAIL drain_state: got %0d want %0d", dut.state, DRAIN);
        end
        man_cnt++;
        repeat (3) @(negedge clk200);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL drain_idle: got %0d want %0d", dut.state, IDLE);
        end
        checks++;
        if (q_addr.size() - base !== 1) begin
            errors++;
            $display("FAIL drain_count: got %0d want 1", q_addr.size() - base);
        end
        arb_en = 1'b1;
        start_frame();
        send_hdr(8'h00, 8'h00, 8'h00, 8'h04);
        send_byte(8'h77, 4);
        end_frame();
        checks++;
        if (q_addr[base+1] !== 20'h2 || q_ub[base+1] !== 1'b1
            || q_data[base+1] !== 8'h77) begin
            errors++;
            $display("FAIL drain_next: got a=%h ub=%b d=%h want 00002 1 77",
                     q_addr[base+1], q_ub[base+1], q_data[base+1]);
        end
    endtask

    task automatic test_reset_settle();
        int base;
        bit found;
        found = 1'b0;
        start_frame();
        send_hdr(8'h80, 8'h00, 8'h12, 8'h34);
        for (int i = 0; i < 40; i++) begin
            if (dut.state === RD_SETTLE) begin
                found = 1'b1;
                break;
            end
            @(negedge clk200);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rs_settle: got no RD_SETTLE want it");
        end
        #3;
        reset = 1'b1;
        cs_active = 1'b0;
        #1;
        checks++;
        if (dut.state !== IDLE || spi_req !== 1'b0) begin
            errors++;
            $display("FAIL rs_async: got st=%0d req=%b want %0d 0",
                     dut.state, spi_req, IDLE);
        end
        checks++;
        if (spi_address !== 20'h0 || spi_ub !== 1'b0
            || spi_read !== 1'b1 || tx_byte !== 8'hFF) begin
            errors++;
            $display("FAIL rs_outs: got a=%h ub=%b rd=%b tx=%h want 0 0 1 ff",
                     spi_address, spi_ub, spi_read, tx_byte);
        end
        @(negedge clk200);
        reset = 1'b0;
        repeat (2) @(negedge clk200);
        base = q_addr.size();
        start_frame();
        send_hdr(8'h00, 8'h00, 8'h00, 8'h06);
        send_byte(8'h99, 4);
        end_frame();
        checks++;
        if (q_addr.size() - base !== 1 || q_rd[base] !== 1'b0
            || q_addr[base] !== 20'h3 || q_ub[base] !== 1'b1
            || q_data[base] !== 8'h99) begin
            errors++;
            $display("FAIL rs_next: got n=%0d a=%h ub=%b d=%h want 1 00003 1 99",
                     q_addr.size() - base, q_addr[base], q_ub[base],
                     q_data[base]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_settle();
        test_overrun();
        test_underrun();
        test_wrap();
        test_drain();
        test_reset_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_sram_bridge.md
SPI_SRAM_BRIDGE -- requirements
Module: spi_sram_bridge

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 5: clocks waited after a read ack match before spi_in_sram_out is sampled.
REQ-002 SHALL have port clk200, input, 1: single 200 MHz clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port cs_active, input, 1: SPI chip select, already synchronised to clk200, high while a transaction runs.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle strobe marking that a received SPI byte is on rx_byte.
REQ-006 SHALL have port rx_byte, input, 8: received SPI byte.
REQ-007 SHALL have port tx_byte, output, 8: byte the SPI slave shifts out at the next byte boundary.
REQ-008 SHALL have port spi_req, output, 1: toggle request to the SRAM arbiter.
REQ-009 SHALL have port spi_ack, input, 1: toggle acknowledge from the arbiter; request pending while spi_req != spi_ack.
REQ-010 SHALL have port spi_read, output, 1: 1 = read, 0 = write.
REQ-011 SHALL have port spi_address, output, 20: SRAM word address.
REQ-012 SHALL have port spi_ub, output, 1: 1 = upper byte lane, 0 = lower.
REQ-013 SHALL have port spi_out_sram_in, output, 8: write byte.
REQ-014 SHALL have port spi_in_sram_out, input, 16: read word from the arbiter.
REQ-015 SHALL have port overrun, output, 1: sticky flag, write byte dropped.
REQ-016 SHALL have port underrun, output, 1: sticky flag, read byte not ready in time.

Function
REQ-017 SHALL use frame format: byte 0 = command (bit7 = 1 read, bit7 = 0 write; bits 6:0 ignored), bytes 1-3 = 24-bit byte address, MSB first (bits 23:21 ignored), then data bytes until cs_active falls.
REQ-018 SHALL map byte address A as: spi_address = A[20:1]; spi_ub = ~A[0] (even byte = upper lane, big-endian).
REQ-019 SHALL have FSM states IDLE, CMD, ADDR2, ADDR1, ADDR0, RD_ISSUE, RD_WAIT, RD_SETTLE, RD_READY, WR_DATA, WR_WAIT, DRAIN.
REQ-020 SHALL go IDLE -> CMD when cs_active rises; CMD -> ADDR2 -> ADDR1 -> ADDR0, each on rx_valid; on the rx_valid in ADDR0, go to RD_ISSUE for a read or WR_DATA for a write.
REQ-021 SHALL issue a request by setting spi_read, spi_address, spi_ub and spi_out_sram_in, and toggling spi_req in the same cycle; these outputs SHALL stay stable until spi_ack == spi_req.
REQ-022 SHALL perform a read as: RD_ISSUE toggles spi_req -> RD_WAIT until ack matches -> RD_SETTLE for SETTLE_CYCLES clocks -> latch the selected lane of spi_in_sram_out (ub ? [15:8] : [7:0]) into tx_byte -> RD_READY; address increments by 1 at the latch.
REQ-023 In RD_READY, on rx_valid, SHALL go to RD_ISSUE for the next prefetch.
REQ-024 If rx_valid arrives in RD_ISSUE, RD_WAIT or RD_SETTLE, SHALL set underrun, drive tx_byte = 8'hFF and continue the prefetch in progress.
REQ-025 SHALL perform a write as: in WR_DATA, on rx_valid, issue a write of rx_byte to the current address, increment the address, go to WR_WAIT; return to WR_DATA when ack matches.
REQ-026 If rx_valid arrives in WR_WAIT, SHALL set overrun and drop the byte.
REQ-027 Address increment SHALL wrap from 21'h1FFFFF to 0.
REQ-028 On cs_active low in any state: with no request pending, go to IDLE; with a request pending, go to DRAIN, wait for the ack match, then go to IDLE. A RD_SETTLE in progress SHALL be abandoned.
REQ-029 rx_valid in IDLE or DRAIN SHALL be ignored; cs_active rising in DRAIN SHALL be held off until IDLE.
REQ-030 Sticky flags SHALL clear at each cs_active rising edge seen in IDLE.
REQ-031 At most one request SHALL be outstanding at any time.

Reset
REQ-032 Reset SHALL force: state IDLE, spi_req 0, spi_read 1, spi_address 0, spi_ub 0, spi_out_sram_in 0, tx_byte 8'hFF, overrun 0, underrun 0, address register 0, settle counter 0.
REQ-033 Reset asserted mid-request SHALL give spi_req 0 regardless of spi_ack; the integrator resets the arbiter in the same reset domain.

Structure
REQ-034 Shared package a314_spi_pkg SHALL hold the FSM state enumeration, the command bit position (7) and the idle tx byte value (8'hFF).
REQ-035 SHALL be a single module, except for one optional sub-module spi_sram_toggle_req holding the req/ack toggle, the pending detect and request-field capture.

Verification
REQ-036 Write frame 00 00 10 00 AA BB -> two requests: addr 20'h00800 ub=1 data AA, then addr 20'h00800 ub=0 data BB; spi_req toggles twice.
REQ-037 Read frame 80 00 00 01 with arbiter returning 16'h1234 -> first request addr 0, ub=0; tx_byte = 8'h34 exactly SETTLE_CYCLES clocks after ack match.
REQ-038 Arbiter ack delayed 20 clocks, two write data bytes 3 clocks apart -> overrun = 1, only the first byte written, one request outstanding.
REQ-039 Read starting at byte address 21'h1FFFFF, two data bytes -> second prefetch to spi_address 0, ub=1 (wrap).
REQ-040 cs_active falls while a write request is pending, ack arrives 10 clocks later -> DRAIN until the ack, then IDLE; no further spi_req toggle.
REQ-041 Reset asserted in RD_SETTLE -> all outputs return to their REQ-032 values asynchronously; next frame decodes correctly.
